// File: rtl/friscv_cache_flush_sched_if.sv
// Signal bundle between the FENCE.i flush scheduler and its neighbours:
// control unit, read issuer, refill writer, flush engine and cache write port.
interface friscv_cache_flush_sched_if #(
  parameter int CACHE_BLOCK_W = 128,
  parameter int AXI_ADDR_W    = 12
);

  // Control unit handshake
  logic                     fence_i_req;
  logic                     fence_i_ack;

  // Read issuer / refill completion tracking
  logic                     ar_block;
  logic                     rd_issue;
  logic                     rd_done;

  // Flush engine handshake
  logic                     flush_blocks;
  logic                     flush_ack;
  logic                     flushing;

  // Flush engine write port
  logic                     fl_wren;
  logic [AXI_ADDR_W-1:0]    fl_waddr;
  logic [CACHE_BLOCK_W-1:0] fl_wdata;

  // Refill writer write port
  logic                     fill_wren;
  logic [AXI_ADDR_W-1:0]    fill_waddr;
  logic [CACHE_BLOCK_W-1:0] fill_wdata;
  logic                     fill_ready;

  // Cache data/tag RAM write port
  logic                     cache_wren;
  logic [AXI_ADDR_W-1:0]    cache_waddr;
  logic [CACHE_BLOCK_W-1:0] cache_wdata;

  // Scheduler side
  modport slave (
    input  fence_i_req, rd_issue, rd_done, flush_ack, flushing,
           fl_wren, fl_waddr, fl_wdata, fill_wren, fill_waddr, fill_wdata,
    output fence_i_ack, ar_block, flush_blocks, fill_ready,
           cache_wren, cache_waddr, cache_wdata
  );

  // Environment side (control unit, issuer, writers, flush engine, RAM)
  modport master (
    output fence_i_req, rd_issue, rd_done, flush_ack, flushing,
           fl_wren, fl_waddr, fl_wdata, fill_wren, fill_waddr, fill_wdata,
    input  fence_i_ack, ar_block, flush_blocks, fill_ready,
           cache_wren, cache_waddr, cache_wdata
  );

endinterface

// File: rtl/friscv_cache_flush_sched.sv
// FENCE.i flush scheduler: drains outstanding AXI reads, requests a cache
// flush, acknowledges the control unit, and arbitrates the cache write port
// between the flush engine and the refill path. Data/address widths are taken
// from the interface instance.
module friscv_cache_flush_sched #(
  parameter int MAX_OSTDREQ = 8
)(
  input  logic aclk,
  input  logic aresetn,
  input  logic srst,
  friscv_cache_flush_sched_if.slave io
);

  localparam int OSTD_W = $clog2(MAX_OSTDREQ + 1);
  localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MAX_OSTDREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state;
  logic [OSTD_W-1:0] ostd;
  logic              fence_i_ack_q;
  logic              flush_blocks_q;
  logic              issue_ok;
  logic              done_ok;

  // A new read only counts below saturation; a completion only counts above zero.
  // Simultaneous issue and completion leave the count untouched.
  assign issue_ok = io.rd_issue && (ostd != OSTD_MAX);
  assign done_ok  = io.rd_done  && (ostd != '0);

  // Flush sequencing; flush_ack only matters in FLUSH so stray pulses are ignored
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      fence_i_ack_q  <= 1'b0;
      flush_blocks_q <= 1'b0;
    end else if (srst) begin
      state          <= IDLE;
      fence_i_ack_q  <= 1'b0;
      flush_blocks_q <= 1'b0;
    end else begin
      fence_i_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.fence_i_req) state <= DRAIN;
        end
        DRAIN: begin
          if ((ostd == '0) && !io.flushing) begin
            state          <= FLUSH;
            flush_blocks_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (io.flush_ack) begin
            state          <= ACK;
            flush_blocks_q <= 1'b0;
            fence_i_ack_q  <= 1'b1;
          end
        end
        ACK: begin
          if (!io.fence_i_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding AXI read counter, saturating at both ends
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ostd <= '0;
    end else if (srst) begin
      ostd <= '0;
    end else if (issue_ok && !io.rd_done) begin
      ostd <= ostd + OSTD_W'(1);
    end else if (done_ok && !io.rd_issue) begin
      ostd <= ostd - OSTD_W'(1);
    end
  end

  assign io.fence_i_ack  = fence_i_ack_q;
  assign io.flush_blocks = flush_blocks_q;
  assign io.ar_block     = (state != IDLE) || (ostd == OSTD_MAX);

  // Refills keep flowing during DRAIN so in-flight reads can land before the flush
  assign io.fill_ready   = !io.flushing && (state != FLUSH);

  // Flush engine owns the write port whenever it is erasing; refills otherwise
  assign io.cache_wren   = io.flushing ? io.fl_wren  : (io.fill_wren && io.fill_ready);
  assign io.cache_waddr  = io.flushing ? io.fl_waddr : io.fill_waddr;
  assign io.cache_wdata  = io.flushing ? io.fl_wdata : io.fill_wdata;

endmodule

// File: tb/tb_friscv_cache_flush_sched.sv
// Self-checking bench for friscv_cache_flush_sched: directed scenarios followed
// by a randomized phase, all compared against a behavioural reference model.
module tb_friscv_cache_flush_sched;

  localparam int CACHE_BLOCK_W = 128;
  localparam int AXI_ADDR_W    = 12;
  localparam int MAX_OSTDREQ   = 8;

  logic aclk;
  logic aresetn;
  logic srst;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a fence request is "in service" from acceptance until the
  // requester releases it after the acknowledge.
  int m_ostd;
  bit m_busy;
  bit m_wait_drain;
  bit m_flush_req;
  bit m_ack;

  friscv_cache_flush_sched_if #(
    .CACHE_BLOCK_W (CACHE_BLOCK_W),
    .AXI_ADDR_W    (AXI_ADDR_W)
  ) bus ();

  friscv_cache_flush_sched #(
    .MAX_OSTDREQ (MAX_OSTDREQ)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .io      (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [CACHE_BLOCK_W-1:0] obs,
                     input logic [CACHE_BLOCK_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ostd       = 0;
    m_busy       = 1'b0;
    m_wait_drain = 1'b0;
    m_flush_req  = 1'b0;
    m_ack        = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelStep();
    int next_ostd;
    if (!aresetn || srst) begin
      modelReset();
    end else begin
      next_ostd = m_ostd + (bus.rd_issue ? 1 : 0) - (bus.rd_done ? 1 : 0);
      if (next_ostd < 0) next_ostd = 0;
      if (next_ostd > MAX_OSTDREQ) next_ostd = MAX_OSTDREQ;
      m_ack = 1'b0;
      if (!m_busy) begin
        if (bus.fence_i_req) begin
          m_busy       = 1'b1;
          m_wait_drain = 1'b1;
        end
      end else if (m_wait_drain) begin
        if (m_ostd == 0 && !bus.flushing) begin
          m_wait_drain = 1'b0;
          m_flush_req  = 1'b1;
        end
      end else if (m_flush_req) begin
        if (bus.flush_ack) begin
          m_flush_req = 1'b0;
          m_ack       = 1'b1;
        end
      end else if (!bus.fence_i_req) begin
        m_busy = 1'b0;
      end
      m_ostd = next_ostd;
    end
  endtask

  task automatic checkOutput(input string step);
    logic exp_ready;
    logic exp_wren;
    exp_ready = !bus.flushing && !m_flush_req;
    exp_wren  = bus.flushing ? bus.fl_wren : (bus.fill_wren && exp_ready);
    chk({step, ":fence_i_ack"},  CACHE_BLOCK_W'(bus.fence_i_ack),  CACHE_BLOCK_W'(m_ack));
    chk({step, ":flush_blocks"}, CACHE_BLOCK_W'(bus.flush_blocks), CACHE_BLOCK_W'(m_flush_req));
    chk({step, ":ar_block"},     CACHE_BLOCK_W'(bus.ar_block),
        CACHE_BLOCK_W'(m_busy || (m_ostd == MAX_OSTDREQ)));
    chk({step, ":fill_ready"},   CACHE_BLOCK_W'(bus.fill_ready),   CACHE_BLOCK_W'(exp_ready));
    chk({step, ":cache_wren"},   CACHE_BLOCK_W'(bus.cache_wren),   CACHE_BLOCK_W'(exp_wren));
    chk({step, ":cache_waddr"},  CACHE_BLOCK_W'(bus.cache_waddr),
        CACHE_BLOCK_W'(bus.flushing ? bus.fl_waddr : bus.fill_waddr));
    chk({step, ":cache_wdata"},  bus.cache_wdata,
        bus.flushing ? bus.fl_wdata : bus.fill_wdata);
  endtask

  // One cycle: randomize write buses, check outputs mid-cycle, step model, clock
  task automatic applyStimulus(input string step);
    bus.fl_wren    = 1'($urandom_range(0, 1));
    bus.fl_waddr   = AXI_ADDR_W'($urandom);
    bus.fl_wdata   = {$urandom, $urandom, $urandom, $urandom};
    bus.fill_wren  = bus.rd_done | 1'($urandom_range(0, 1));
    bus.fill_waddr = AXI_ADDR_W'($urandom);
    bus.fill_wdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checkOutput(step);
    modelStep();
    @(posedge aclk);
    #1;
    bus.rd_issue  = 1'b0;
    bus.rd_done   = 1'b0;
    bus.flush_ack = 1'b0;
  endtask

  initial begin
    bit ack_seen;
    aresetn         = 1'b0;
    srst            = 1'b0;
    bus.fence_i_req = 1'b0;
    bus.rd_issue    = 1'b0;
    bus.rd_done     = 1'b0;
    bus.flush_ack   = 1'b0;
    bus.flushing    = 1'b0;
    modelReset();
    @(posedge aclk);
    #1;

    $display("[TB] reset state");
    applyStimulus("reset");
    applyStimulus("reset");
    aresetn = 1'b1;

    $display("[TB] init flush, flush engine owns the write port");
    bus.flushing = 1'b1;
    for (int i = 0; i < 33; i++) applyStimulus("init_flush");
    bus.flushing  = 1'b0;
    bus.flush_ack = 1'b1;
    applyStimulus("init_done_stray_ack");
    applyStimulus("idle");

    $display("[TB] plain fence with idle read path");
    bus.fence_i_req = 1'b1;
    for (int c = 0; c < 46; c++) begin
      if (c == 40) bus.flush_ack = 1'b1;
      if (c == 43) bus.fence_i_req = 1'b0;
      applyStimulus("fence_basic");
    end

    $display("[TB] fence waits for outstanding reads");
    for (int i = 0; i < 3; i++) begin
      bus.rd_issue = 1'b1;
      applyStimulus("drain_issue");
    end
    bus.fence_i_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("drain_wait");
    for (int i = 0; i < 3; i++) begin
      bus.rd_done = 1'b1;
      applyStimulus("drain_refill");
      applyStimulus("drain_gap");
    end
    for (int i = 0; i < 3; i++) applyStimulus("drain_flush");
    bus.flush_ack = 1'b1;
    applyStimulus("drain_ack");
    applyStimulus("drain_ack_hold");
    bus.fence_i_req = 1'b0;
    applyStimulus("drain_release");
    applyStimulus("drain_idle");

    $display("[TB] outstanding counter boundaries");
    bus.rd_done = 1'b1;
    applyStimulus("ostd_underflow");
    for (int i = 0; i < 2; i++) begin
      bus.rd_issue = 1'b1;
      applyStimulus("ostd_to_two");
    end
    bus.rd_issue = 1'b1;
    bus.rd_done  = 1'b1;
    applyStimulus("ostd_both");
    applyStimulus("ostd_hold_two");
    for (int i = 0; i < 6; i++) begin
      bus.rd_issue = 1'b1;
      applyStimulus("ostd_to_max");
    end
    bus.rd_issue = 1'b1;
    applyStimulus("ostd_ninth");
    applyStimulus("ostd_at_max");
    bus.rd_issue = 1'b1;
    bus.rd_done  = 1'b1;
    applyStimulus("ostd_both_at_max");
    for (int i = 0; i < 9; i++) begin
      bus.rd_done = 1'b1;
      applyStimulus("ostd_drain");
    end
    applyStimulus("ostd_zero");

    $display("[TB] stray flush_ack in IDLE and DRAIN, fence during init flush");
    bus.flush_ack = 1'b1;
    applyStimulus("stray_idle");
    bus.flushing    = 1'b1;
    bus.fence_i_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("stray_drain_wait");
    bus.flush_ack = 1'b1;
    applyStimulus("stray_drain");
    applyStimulus("stray_drain_after");
    bus.flushing = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("own_flush");
    bus.flush_ack = 1'b1;
    applyStimulus("own_flush_ack");
    bus.fence_i_req = 1'b0;
    applyStimulus("own_release");
    applyStimulus("own_idle");

    $display("[TB] async reset while flushing");
    bus.fence_i_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("arst_to_flush");
    bus.rd_issue = 1'b1;
    applyStimulus("arst_issue");
    aresetn         = 1'b0;
    bus.fence_i_req = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_immediate");
    applyStimulus("arst_hold");
    applyStimulus("arst_hold");
    aresetn = 1'b1;
    applyStimulus("arst_released");

    $display("[TB] sync reset while draining");
    bus.rd_issue = 1'b1;
    applyStimulus("srst_issue");
    bus.flushing    = 1'b1;
    bus.fence_i_req = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus("srst_drain");
    srst            = 1'b1;
    bus.fence_i_req = 1'b0;
    applyStimulus("srst_edge");
    srst         = 1'b0;
    bus.flushing = 1'b0;
    applyStimulus("srst_after");
    applyStimulus("srst_idle");

    $display("[TB] randomized traffic");
    ack_seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.fence_i_req) begin
        if ($urandom_range(0, 7) == 0) bus.fence_i_req = 1'b1;
      end else if (ack_seen && $urandom_range(0, 2) == 0) begin
        bus.fence_i_req = 1'b0;
        ack_seen        = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) bus.flushing = ~bus.flushing;
      bus.rd_issue  = 1'($urandom_range(0, 2) == 0);
      bus.rd_done   = 1'($urandom_range(0, 2) == 0);
      bus.flush_ack = 1'($urandom_range(0, 4) == 0);
      srst          = 1'($urandom_range(0, 99) == 0);
      if (srst) ack_seen = 1'b0;
      applyStimulus("random");
      if (m_ack) ack_seen = 1'b1;
    end
    srst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/friscv_cache_flush_sched.md
Name: friscv_cache_flush_sched

Overview:
- Schedules FENCE.i cache flushes and arbitrates the cache write port between the flush engine and the refill (AXI read-completion) path.
- Drains outstanding AXI read requests before flushing, so no stale refill lands after the flush.
- Sits between the control unit, the read-request issuer, the refill writer, the flush engine and the cache data/tag RAM write port.

Parameters:
- CACHE_BLOCK_W, 128, cache block payload width in bits.
- AXI_ADDR_W, 12, cache write address width.
- MAX_OSTDREQ, 8, maximum outstanding AXI read requests; counter width is $clog2(MAX_OSTDREQ+1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset
- fence_i_req  in  1  level flush request from control unit; held until fence_i_ack
- fence_i_ack  out  1  one-cycle pulse, flush complete
- ar_block  out  1  high = read issuer must not issue a new AR
- rd_issue  in  1  pulse per AR handshake
- rd_done  in  1  pulse per completed refill write (last beat)
- flush_blocks  out  1  request to flush engine, held until flush_ack
- flush_ack  in  1  flush engine completion pulse
- flushing  in  1  flush engine currently owns/erases cache
- fl_wren  in  1  flush engine write enable
- fl_waddr  in  AXI_ADDR_W  flush engine write address
- fl_wdata  in  CACHE_BLOCK_W  flush engine write data
- fill_wren  in  1  refill write enable
- fill_waddr  in  AXI_ADDR_W  refill write address
- fill_wdata  in  CACHE_BLOCK_W  refill write data
- fill_ready  out  1  refill write accepted this cycle
- cache_wren  out  1  cache write enable
- cache_waddr  out  AXI_ADDR_W  cache write address
- cache_wdata  out  CACHE_BLOCK_W  cache write data

Behaviour:
- aresetn low, or srst high at a clock edge, gives:
  - state=IDLE, ostd=0, fence_i_ack=0, flush_blocks=0.
  - ar_block and fill_ready then follow the combinational rules below.
- A reset mid-operation abandons any drain or flush; flush_blocks drops immediately (async) or next edge (srst); no ack is produced.
- FSM states are IDLE, DRAIN, FLUSH, ACK.
  - IDLE: fence_i_req=1 -> DRAIN.
  - DRAIN: when ostd==0 and flushing==0 -> FLUSH, and flush_blocks<=1 on the same edge.
  - FLUSH: flush_blocks stays 1 until flush_ack=1. On flush_ack -> ACK, with flush_blocks<=0 and fence_i_ack<=1 (exactly one cycle).
  - ACK: fence_i_ack<=0. fence_i_req==0 -> IDLE; otherwise stay, no second ack.
- flush_ack is ignored in IDLE, DRAIN and ACK. This covers the reset-time self-initialisation flush completing while the FSM is in DRAIN; gating DRAIN exit on flushing==0 guarantees any flush_ack seen in FLUSH belongs to the request.
- Minimum latency is 2 edges from fence_i_req to flush_blocks, i.e. fence_i_req sampled high at edge 1 gives flush_blocks high after edge 2 when ostd==0 and flushing==0.
- ar_block (combinational) = (state != IDLE) or (ostd == MAX_OSTDREQ).
- Outstanding counter (ostd):
  - +1 on rd_issue, -1 on rd_done.
  - Both in the same cycle: unchanged.
  - rd_done at ostd==0: ignored, no underflow.
  - rd_issue at MAX_OSTDREQ: ignored, saturate.
- fill_ready (combinational) = !flushing and state != FLUSH. Refills are accepted in DRAIN so in-flight reads can complete.
- Write-port mux (combinational, zero latency):
  - If flushing: cache_* = fl_*.
  - Else: cache_wren = fill_wren & fill_ready, and cache_waddr/wdata = fill_*.
  - cache_wren is never asserted by both sources in the same cycle.
- A refill write presented while fill_ready=0 is not written. The refill writer holds it until fill_ready=1.
- fence_i_req rising while flushing=1 (initialisation flush) waits in DRAIN until flushing falls, then issues its own flush.

Test Plan:
- Reset, flush engine runs init flush (flushing=1 for 33 cycles) -> cache_* mirrors fl_*; fill_ready=0 throughout; fence_i_ack stays 0.
- ostd=0, idle, fence_i_req=1 at cycle 0 -> ar_block=1 from cycle 1; flush_blocks=1 from cycle 2; flush_ack at cycle 40 -> fence_i_ack pulse at cycle 41 only; after fence_i_req=0, IDLE and ar_block=0.
- 3 rd_issue pulses, then fence_i_req -> stays in DRAIN, flush_blocks=0; 3 rd_done refills written via fill path; flush_blocks=1 on the edge after ostd reaches 0.
- rd_issue and rd_done in the same cycle with ostd=2 -> ostd stays 2; 8 issues -> ar_block=1; a 9th issue is ignored and ostd=8.
- Stray flush_ack pulses in IDLE and DRAIN -> no state change and no fence_i_ack.
- aresetn low while in FLUSH -> flush_blocks=0 and fence_i_ack=0 immediately, state IDLE, ostd=0; srst in DRAIN -> same on the next edge.
